// File: rtl/phase_arbiter.sv
// Green-time scheduler for one intersection: sequences GREEN/YELLOW/ALLRED among
// main, left-turn, secondary and pedestrian phases with aging and emergency preemption.
module phase_arbiter #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1,
    parameter int AGE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] main_num,
    input  logic [2:0] left_num,
    input  logic [2:0] sec_num,
    input  logic [2:0] p_num,
    input  logic       s_emergency,
    output logic [3:0] grant,
    output logic [1:0] stage,
    output logic [3:0] m_LRYG,
    output logic [2:0] s_RYG,
    output logic       p,
    output logic       phase_start
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } stage_t;

    localparam int TW = $clog2(MAX_GREEN + YELLOW + ALL_RED);
    localparam int AW = $clog2(AGE_LIMIT + 1);

    localparam logic [1:0] PH_MAIN = 2'd0;
    localparam logic [1:0] PH_LEFT = 2'd1;
    localparam logic [1:0] PH_SEC  = 2'd2;
    localparam logic [1:0] PH_PED  = 2'd3;

    stage_t          st_q, st_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [1:0]      cur_q, cur_d, nxt_q, nxt_d;
    logic [AW-1:0]   age_q [4];
    logic [AW-1:0]   age_d [4];
    logic            start_d;
    logic [3:0]      m_d;
    logic [2:0]      s_d;
    logic            p_d;
    logic [2:0]      cnt [4];

    logic            other_demand, gap_out, max_out, emerg_exit, sec_hold, found_aged;
    logic [2:0]      best_cnt;
    logic [1:0]      pick, idx, new_ph;

    assign cnt[0] = main_num;
    assign cnt[1] = left_num;
    assign cnt[2] = sec_num;
    assign cnt[3] = p_num;

    // Next-state, candidate selection and lamp decode for the registered outputs
    always_comb begin
        st_d         = st_q;
        tmr_d        = tmr_q;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        age_d        = age_q;
        start_d      = 1'b0;
        other_demand = 1'b0;
        gap_out      = 1'b0;
        max_out      = 1'b0;
        emerg_exit   = 1'b0;
        sec_hold     = 1'b0;
        found_aged   = 1'b0;
        best_cnt     = '0;
        pick         = PH_SEC;
        idx          = cur_q;
        new_ph       = nxt_q;

        for (int i = 0; i < 4; i++) begin
            if (2'(i) != cur_q && cnt[i] != '0) other_demand = 1'b1;
        end

        if (!s_emergency) begin
            for (int i = 0; i < 4; i++) begin
                if (!found_aged && 2'(i) != cur_q && cnt[i] != '0 &&
                    age_q[i] == AW'(AGE_LIMIT)) begin
                    pick       = 2'(i);
                    found_aged = 1'b1;
                end
            end
            if (!found_aged) begin
                // Strict compare in rotation order hands ties to the earliest candidate
                pick = cur_q;
                for (int k = 1; k < 4; k++) begin
                    idx = cur_q + 2'(k);
                    if (cnt[idx] > best_cnt) begin
                        best_cnt = cnt[idx];
                        pick     = idx;
                    end
                end
            end
        end

        case (st_q)
            ST_GREEN: begin
                emerg_exit = s_emergency && (cur_q != PH_SEC);
                sec_hold   = s_emergency && (cur_q == PH_SEC);
                gap_out    = (tmr_q >= TW'(MIN_GREEN - 1)) && (cnt[cur_q] == '0) && other_demand;
                max_out    = (tmr_q == TW'(MAX_GREEN - 1)) && other_demand;
                if (emerg_exit || (!sec_hold && (gap_out || max_out))) begin
                    st_d  = ST_YELLOW;
                    tmr_d = '0;
                    nxt_d = pick;
                end else if (tmr_q < TW'(MAX_GREEN - 1)) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_YELLOW: begin
                if (s_emergency) nxt_d = PH_SEC;
                if (tmr_q == TW'(YELLOW - 1)) begin
                    st_d  = ST_ALLRED;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_ALLRED: begin
                new_ph = s_emergency ? PH_SEC : nxt_q;
                nxt_d  = new_ph;
                if (tmr_q == TW'(ALL_RED - 1)) begin
                    st_d    = ST_GREEN;
                    tmr_d   = '0;
                    cur_d   = new_ph;
                    start_d = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (2'(i) == new_ph)
                            age_d[i] = '0;
                        else if (cnt[i] != '0 && age_q[i] != AW'(AGE_LIMIT))
                            age_d[i] = age_q[i] + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                st_d  = ST_GREEN;
                tmr_d = '0;
            end
        endcase

        m_d = 4'b0100;
        s_d = 3'b100;
        p_d = 1'b0;
        case (cur_d)
            PH_MAIN: m_d = (st_d == ST_GREEN) ? 4'b0001 : (st_d == ST_YELLOW) ? 4'b0010 : 4'b0100;
            PH_LEFT: m_d = (st_d == ST_GREEN) ? 4'b1100 : (st_d == ST_YELLOW) ? 4'b0110 : 4'b0100;
            PH_SEC:  s_d = (st_d == ST_GREEN) ? 3'b001  : (st_d == ST_YELLOW) ? 3'b010  : 3'b100;
            PH_PED:  p_d = (st_d == ST_GREEN);
            default: m_d = 4'b0100;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= ST_GREEN;
            tmr_q       <= '0;
            cur_q       <= PH_MAIN;
            nxt_q       <= PH_MAIN;
            for (int i = 0; i < 4; i++) age_q[i] <= '0;
            grant       <= 4'b0001;
            stage       <= 2'b00;
            m_LRYG      <= 4'b0001;
            s_RYG       <= 3'b100;
            p           <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            st_q        <= st_d;
            tmr_q       <= tmr_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            age_q       <= age_d;
            grant       <= 4'b0001 << cur_d;
            stage       <= st_d;
            m_LRYG      <= m_d;
            s_RYG       <= s_d;
            p           <= p_d;
            phase_start <= start_d;
        end
    end

endmodule

// File: tb/tb_phase_arbiter.sv
// Self-checking bench for phase_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the scheduling rules.
module tb_phase_arbiter;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 12;
    localparam int YELLOW    = 3;
    localparam int ALL_RED   = 1;
    localparam int AGE_LIMIT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] main_num = '0, left_num = '0, sec_num = '0, p_num = '0;
    logic       s_emergency = 1'b0;
    logic [3:0] grant;
    logic [1:0] stage;
    logic [3:0] m_LRYG;
    logic [2:0] s_RYG;
    logic       p;
    logic       phase_start;

    int checks = 0;
    int errors = 0;

    // Behavioural model: stage 0/1/2 = green/yellow/allred, phases 0..3
    int m_stage, m_timer, m_g, m_nxt, m_start;
    int m_age [4];

    phase_arbiter #(
        .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW(YELLOW),
        .ALL_RED(ALL_RED), .AGE_LIMIT(AGE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .main_num(main_num), .left_num(left_num), .sec_num(sec_num), .p_num(p_num),
        .s_emergency(s_emergency),
        .grant(grant), .stage(stage), .m_LRYG(m_LRYG), .s_RYG(s_RYG),
        .p(p), .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        m_stage = 0; m_timer = 0; m_g = 0; m_nxt = 0; m_start = 0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    function automatic int pickNext(input int c[4]);
        int best, bestc;
        if (s_emergency) return 2;
        for (int i = 0; i < 4; i++)
            if (i != m_g && c[i] > 0 && m_age[i] == AGE_LIMIT) return i;
        best = m_g; bestc = 0;
        for (int k = 1; k < 4; k++) begin
            if (c[(m_g + k) % 4] > bestc) begin
                best  = (m_g + k) % 4;
                bestc = c[best];
            end
        end
        return best;
    endfunction

    task automatic modelStep();
        int  c[4];
        bit  other, leave;
        c = '{int'(main_num), int'(left_num), int'(sec_num), int'(p_num)};
        m_start = 0;
        case (m_stage)
            0: begin
                other = 0;
                for (int i = 0; i < 4; i++) if (i != m_g && c[i] > 0) other = 1;
                if (s_emergency) leave = (m_g != 2);
                else leave = other && ((m_timer >= MIN_GREEN - 1 && c[m_g] == 0) ||
                                       m_timer == MAX_GREEN - 1);
                if (leave) begin
                    m_nxt = pickNext(c); m_stage = 1; m_timer = 0;
                end else if (m_timer < MAX_GREEN - 1) m_timer++;
            end
            1: begin
                if (s_emergency) m_nxt = 2;
                if (m_timer == YELLOW - 1) begin m_stage = 2; m_timer = 0; end
                else m_timer++;
            end
            default: begin
                if (s_emergency) m_nxt = 2;
                if (m_timer == ALL_RED - 1) begin
                    m_g = m_nxt; m_stage = 0; m_timer = 0; m_start = 1;
                    for (int i = 0; i < 4; i++) begin
                        if (i == m_g) m_age[i] = 0;
                        else if (c[i] > 0 && m_age[i] < AGE_LIMIT) m_age[i]++;
                    end
                end else m_timer++;
            end
        endcase
    endtask

    function automatic logic [3:0] expM(input int g, input int st);
        if (g == 0) return (st == 0) ? 4'b0001 : (st == 1) ? 4'b0010 : 4'b0100;
        if (g == 1) return (st == 0) ? 4'b1100 : (st == 1) ? 4'b0110 : 4'b0100;
        return 4'b0100;
    endfunction

    function automatic logic [2:0] expS(input int g, input int st);
        if (g == 2) return (st == 0) ? 3'b001 : (st == 1) ? 3'b010 : 3'b100;
        return 3'b100;
    endfunction

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk4({tag, ".grant"}, grant, 4'(1 << m_g));
        chk4({tag, ".stage"}, {2'b00, stage}, 4'(m_stage));
        chk4({tag, ".m_LRYG"}, m_LRYG, expM(m_g, m_stage));
        chk4({tag, ".s_RYG"}, {1'b0, s_RYG}, {1'b0, expS(m_g, m_stage)});
        chk4({tag, ".p"}, {3'b000, p}, {3'b000, (m_g == 3 && m_stage == 0)});
        chk4({tag, ".phase_start"}, {3'b000, phase_start}, 4'(m_start));
    endtask

    // Called with time just after a falling edge; returns at the next falling edge
    task automatic applyStimulus(input logic [2:0] mn, input logic [2:0] ln,
                                 input logic [2:0] sn, input logic [2:0] pn,
                                 input logic e, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            main_num = mn; left_num = ln; sec_num = sn; p_num = pn; s_emergency = e;
            @(posedge clk);
            modelStep();
            #1;
            checkOutput("cycle");
            @(negedge clk);
        end
    endtask

    // Reset is raised mid low-phase and checked before any clock edge arrives
    task automatic resetPulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [2:0] rndCnt();
        return ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    endfunction

    initial begin
        bit saw_ped;
        modelReset();

        resetPulse("reset");
        applyStimulus(0, 0, 0, 0, 0, 50);
        chk4("idle_grant", grant, 4'b0001);

        resetPulse("reset_gap");
        applyStimulus(0, 0, 4, 0, 0, MIN_GREEN - 1);
        chk4("gap_still_green", {2'b00, stage}, 4'b0000);
        applyStimulus(0, 0, 4, 0, 0, 1);
        chk4("gap_yellow_m", m_LRYG, 4'b0010);
        applyStimulus(0, 0, 4, 0, 0, YELLOW);
        chk4("gap_allred_m", m_LRYG, 4'b0100);
        applyStimulus(0, 0, 4, 0, 0, ALL_RED);
        chk4("gap_sec_grant", grant, 4'b0100);
        chk4("gap_sec_lamp", {1'b0, s_RYG}, 4'b0001);
        chk4("gap_start_pulse", {3'b000, phase_start}, 4'b0001);
        applyStimulus(0, 0, 4, 0, 0, 1);
        chk4("gap_start_drop", {3'b000, phase_start}, 4'b0000);

        resetPulse("reset_max1");
        applyStimulus(7, 2, 4, 2, 0, MAX_GREEN - 1);
        chk4("max1_green", {2'b00, stage}, 4'b0000);
        applyStimulus(7, 2, 4, 2, 0, 1 + YELLOW + ALL_RED);
        chk4("max1_grant", grant, 4'b0100);

        resetPulse("reset_max2");
        applyStimulus(7, 4, 4, 2, 0, MAX_GREEN + YELLOW + ALL_RED);
        chk4("max2_grant", grant, 4'b0010);
        chk4("max2_lamp", m_LRYG, 4'b1100);

        resetPulse("reset_emerg");
        applyStimulus(7, 0, 3, 0, 0, 1);
        applyStimulus(7, 0, 3, 0, 1, 1);
        chk4("emerg_yellow", {2'b00, stage}, 4'b0001);
        applyStimulus(7, 0, 3, 0, 1, YELLOW + ALL_RED);
        chk4("emerg_sec", grant, 4'b0100);
        applyStimulus(7, 0, 3, 0, 1, 20);
        chk4("emerg_hold", {2'b00, stage}, 4'b0000);
        applyStimulus(7, 0, 3, 0, 0, 1);
        chk4("emerg_release", {2'b00, stage}, 4'b0001);

        resetPulse("reset_starve");
        saw_ped = 0;
        for (int n = 0; n < 150; n++) begin
            applyStimulus(3'($urandom_range(5, 7)), 3'($urandom_range(5, 7)),
                          3'($urandom_range(5, 7)), 3'd1, 0, 1);
            if (grant == 4'b1000 && stage == 2'b00) saw_ped = 1;
        end
        chk4("starve_ped_granted", {3'b000, saw_ped}, 4'b0001);

        resetPulse("reset_mid");
        applyStimulus(0, 0, 4, 0, 0, MIN_GREEN + YELLOW + ALL_RED);
        applyStimulus(3, 0, 0, 0, 0, MIN_GREEN + 1);
        chk4("mid_sec_yellow", {grant[2], 1'b0, stage}, 4'b1001);
        resetPulse("mid_reset");
        chk4("mid_reset_m", m_LRYG, 4'b0001);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(rndCnt(), rndCnt(), rndCnt(), rndCnt(),
                          ($urandom_range(0, 9) == 0), $urandom_range(3, 15));
            if ($urandom_range(0, 19) == 0) resetPulse("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
